// File: rtl/ak_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: chunk-width
// derivation and the parameter legality rule used at elaboration.
package ak_addsub_pkg;

    // Width of one pipeline chunk of the carry chain.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal when 1 <= stages <= width and the width splits evenly.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/ak_addsub_chunk.sv
// CW-bit ripple adder built from full adder cells. Besides the carry out
// it exposes the carry into its top bit, which the last chunk uses to
// derive signed overflow.
module ak_addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        ak_addsub_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_s[i]),
            .s  (sum[i]),
            .co (c_s[i+1])
        );
    end

    assign cout  = c_s[CW];
    assign c_msb = c_s[CW-1];

endmodule

// File: rtl/ak_addsub_fa.sv
// 1-bit full adder cell, the building block of each ripple chunk.
module ak_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ak_addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is split
// into STAGES chunks; each pipeline register carries a 2*WIDTH word
// {B-operand (already inverted for subtract), A-operand/partial-sum}.
// Chunk k of the lower half is overwritten by its sum as the word passes
// stage k, so upper A/B chunks are skewed and finished sum chunks are
// deskewed by the same registers, and the last stage holds the full result.
// A single advance enable moves every stage (bubbles included) or holds all.
module ak_addsub_pipe
    import ak_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW  = chunk_width(WIDTH, STAGES);
    localparam int OPW = 2 * WIDTH;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("ak_addsub_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             adv_s;
    logic [OPW-1:0]   op_in_s  [STAGES];
    logic             c_in_s   [STAGES];
    logic             v_in_s   [STAGES];
    logic [CW-1:0]    sum_s    [STAGES];
    logic             co_s     [STAGES];
    logic             cm_s     [STAGES];
    logic [OPW-1:0]   op_nxt_s [STAGES];
    logic [WIDTH-1:0] res_fin_s;

    logic [OPW-1:0]   op_d [STAGES];
    logic [OPW-1:0]   op_q [STAGES];
    logic             c_d  [STAGES];
    logic             c_q  [STAGES];
    logic             v_d  [STAGES];
    logic             v_q  [STAGES];
    logic             ovf_d;
    logic             ovf_q;
    logic             zero_d;
    logic             zero_q;
    logic             neg_d;
    logic             neg_q;

    // The whole pipe moves when the output slot is free or being drained.
    assign adv_s    = out_ready | ~v_q[STAGES-1];
    assign in_ready = adv_s;

    // Stage 0 takes operands straight from the ports; subtract inverts B
    // and injects the +1 as the first carry-in, so m needs no further travel.
    assign op_in_s[0] = {B ^ {WIDTH{m}}, A};
    assign c_in_s[0]  = m;
    assign v_in_s[0]  = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign op_in_s[k] = op_q[k-1];
        assign c_in_s[k]  = c_q[k-1];
        assign v_in_s[k]  = v_q[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        ak_addsub_chunk #(
            .CW (CW)
        ) u_chunk (
            .a     (CW'(op_in_s[k] >> (k * CW))),
            .b     (CW'(op_in_s[k] >> (WIDTH + k * CW))),
            .cin   (c_in_s[k]),
            .sum   (sum_s[k]),
            .cout  (co_s[k]),
            .c_msb (cm_s[k])
        );
    end

    // Next state of every stage and of the flags: shift on advance, else hold.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            op_nxt_s[k]                 = op_in_s[k];
            op_nxt_s[k][k * CW +: CW]   = sum_s[k];
            if (adv_s) begin
                op_d[k] = op_nxt_s[k];
                c_d[k]  = co_s[k];
                v_d[k]  = v_in_s[k];
            end else begin
                op_d[k] = op_q[k];
                c_d[k]  = c_q[k];
                v_d[k]  = v_q[k];
            end
        end
        res_fin_s = op_nxt_s[STAGES-1][WIDTH-1:0];
        if (adv_s) begin
            ovf_d  = cm_s[STAGES-1] ^ co_s[STAGES-1];
            zero_d = ~|res_fin_s;
            neg_d  = res_fin_s[WIDTH-1];
        end else begin
            ovf_d  = ovf_q;
            zero_d = zero_q;
            neg_d  = neg_q;
        end
    end

    // Pipeline and output flag registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                op_q[k] <= {OPW{1'b0}};
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                op_q[k] <= op_d[k];
                c_q[k]  <= c_d[k];
                v_q[k]  <= v_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign result    = op_q[STAGES-1][WIDTH-1:0];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_ak_addsub_pipe.sv
// Directed self-checking bench for ak_addsub_pipe (STAGES = 4, 1 and 16).
module tb_ak_addsub_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance, WIDTH=16 STAGES=4
    logic        in_valid = 1'b0, in_ready, m = 1'b0, out_valid, out_ready = 1'b1;
    logic        cout, ovf, zero, neg;
    logic [15:0] a = 16'h0000, b = 16'h0000, result;

    ak_addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    // STAGES=1 instance
    logic        iv1 = 1'b0, ir1, m1 = 1'b0, ov1, c1, o1, z1, n1;
    logic [15:0] a1 = 16'h0000, b1 = 16'h0000, r1;

    ak_addsub_pipe #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .A(a1), .B(b1), .m(m1), .out_valid(ov1), .out_ready(1'b1),
        .result(r1), .cout(c1), .ovf(o1), .zero(z1), .neg(n1)
    );

    // STAGES=16 instance
    logic        iv16 = 1'b0, ir16, m16 = 1'b0, ov16, c16, o16, z16, n16;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000, r16;

    ak_addsub_pipe #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .m(m16), .out_valid(ov16), .out_ready(1'b1),
        .result(r16), .cout(c16), .ovf(o16), .zero(z16), .neg(n16)
    );

    // Hand-computed directed vectors; flags packed as {cout, ovf, zero, neg}
    localparam logic [15:0] TA [6] = '{16'h00FF, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h1234};
    localparam logic [15:0] TB [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
    localparam logic        TM [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [15:0] TR [6] = '{16'h0100, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h0000};
    localparam logic [3:0]  TF [6] = '{4'b0000, 4'b0101, 4'b1010, 4'b0001, 4'b1100, 4'b1010};

    // Reference: {cout, ovf, zero, neg, result}; overflow from operand/result signs
    function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv, input logic mv);
        logic [15:0] bb;
        logic [16:0] s;
        logic [15:0] r;
        logic        o;
        bb = mv ? ~bv : bv;
        s  = {1'b0, av} + {1'b0, bb} + {16'd0, mv};
        r  = s[15:0];
        o  = (av[15] == bb[15]) && (r[15] != av[15]);
        return {s[16], o, (r == 16'd0), r[15], r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf, zero, neg} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cout, ovf, zero, neg}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (ov1 !== 1'b0 || ov16 !== 1'b0) begin errors++; $display("FAIL reset_variants_valid: got %b%b expected 00", ov1, ov16); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
            a = TA[i]; b = TB[i]; m = TM[i]; in_valid = 1'b1;
            lat = 0;
            do begin
                @(posedge clk); @(negedge clk);
                in_valid = 1'b0; lat++;
            end while (out_valid !== 1'b1 && lat < 20);
            checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (result !== TR[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, result, TR[i]); end
            checks++; if ({cout, ovf, zero, neg} !== TF[i]) begin errors++; $display("FAIL dir%0d_flags: got %b expected %b", i, {cout, ovf, zero, neg}, TF[i]); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_q [8];
        logic        exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_v = (c >= 4 && c < 12) ? 1'b1 : 1'b0;
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid_c%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v && out_valid === 1'b1) begin
                checks++;
                if ({cout, ovf, zero, neg, result} !== exp_q[c-4]) begin
                    errors++; $display("FAIL b2b_data_c%0d: got %h expected %h", c, {cout, ovf, zero, neg, result}, exp_q[c-4]);
                end
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_c%0d: got %b expected 1", c, in_ready); end
            if (c < 8) begin
                a = 16'(16'h9000 + c * 16'h1357);
                b = 16'(16'h4321 ^ (c * 16'h0F0F));
                m = c[0];
                in_valid = 1'b1;
                exp_q[c] = model(a, b, m);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] sb [$];
        logic [19:0] held;
        logic        was_stalled;
        int          sent;
        int          got;
        sent = 0; got = 0; was_stalled = 1'b0; held = 20'h0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
            #1;
            if (was_stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {cout, ovf, zero, neg, result} !== held) begin
                    errors++; $display("FAIL bp_hold_c%0d: got %b/%h expected 1/%h", c, out_valid, {cout, ovf, zero, neg, result}, held);
                end
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_stall_c%0d: got in_ready %b out_valid %b expected 0 1", c, in_ready, out_valid);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_extra_c%0d: got %h expected no output", c, {cout, ovf, zero, neg, result});
                end else begin
                    if ({cout, ovf, zero, neg, result} !== sb[0]) begin
                        errors++; $display("FAIL bp_order_c%0d: got %h expected %h", c, {cout, ovf, zero, neg, result}, sb[0]);
                    end
                    void'(sb.pop_front());
                    got++;
                end
            end
            was_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
            held = {cout, ovf, zero, neg, result};
            if (sent < 6) begin
                a = 16'(16'h1111 * (sent + 1));
                b = 16'(16'h0F00 + sent * 16'h0123);
                m = (sent % 3 == 0) ? 1'b1 : 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb.push_back(model(a, b, m));
                sent++;
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup_c%0d: got %b expected 0", c, out_valid); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = (c == 0) ? 16'hFFFF : 16'(16'h1234 + c * 16'h0101);
            b = (c == 0) ? 16'h0001 : 16'h4321;
            m = (c == 1) ? 1'b1 : 1'b0;
            in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || {cout, ovf, zero, neg} !== 4'b1010) begin
            errors++; $display("FAIL rst_pre: got %b %h %b expected 1 0000 1010", out_valid, result, {cout, ovf, zero, neg});
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_async_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf, zero, neg} !== 4'b0000) begin errors++; $display("FAIL rst_async_flags: got %b expected 0000", {cout, ovf, zero, neg}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flushed_c%0d: got %b expected 0", c, out_valid); end
        end
        a = 16'h1234; b = 16'h1111; m = 1'b0; in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0; lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        checks++; if (lat != 4) begin errors++; $display("FAIL rst_post_latency: got %0d expected 4", lat); end
        checks++; if (result !== 16'h2345 || {cout, ovf, zero, neg} !== 4'b0000) begin
            errors++; $display("FAIL rst_post_data: got %h %b expected 2345 0000", result, {cout, ovf, zero, neg});
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_stage_variants();
        int lat;
        a1 = 16'h00FF; b1 = 16'h0001; m1 = 1'b0; iv1 = 1'b1;
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL s1_in_ready: got %b expected 1", ir1); end
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk);
            iv1 = 1'b0; lat++;
        end while (ov1 !== 1'b1 && lat < 40);
        checks++; if (lat != 1) begin errors++; $display("FAIL s1_latency: got %0d expected 1", lat); end
        checks++; if (r1 !== 16'h0100 || {c1, o1, z1, n1} !== 4'b0000) begin
            errors++; $display("FAIL s1_data: got %h %b expected 0100 0000", r1, {c1, o1, z1, n1});
        end
        a16 = 16'h00FF; b16 = 16'h0001; m16 = 1'b0; iv16 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk);
            iv16 = 1'b0; lat++;
        end while (ov16 !== 1'b1 && lat < 40);
        checks++; if (lat != 16) begin errors++; $display("FAIL s16_latency: got %0d expected 16", lat); end
        checks++; if (r16 !== 16'h0100 || {c16, o16, z16, n16} !== 4'b0000) begin
            errors++; $display("FAIL s16_data: got %h %b expected 0100 0000", r16, {c16, o16, z16, n16});
        end
        a16 = 16'h8000; b16 = 16'h0001; m16 = 1'b1; iv16 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk);
            iv16 = 1'b0; lat++;
        end while (ov16 !== 1'b1 && lat < 40);
        checks++; if (lat != 16 || r16 !== 16'h7FFF || {c16, o16, z16, n16} !== 4'b1100) begin
            errors++; $display("FAIL s16_sub: got %0d %h %b expected 16 7fff 1100", lat, r16, {c16, o16, z16, n16});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_stage_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ak_addsub_pipe.md
Name: ak_addsub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor, WIDTH bits wide, carry chain split into STAGES registered chunks. Mode bit m is carried per transaction: 0 = A+B, 1 = A-B, implemented as A + ~B + 1. Valid/ready handshake on both sides; one operation accepted per cycle. Sits between operand sources and ALU/accumulator consumers that previously used the fixed 8-bit combinational add/sub.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands A, B, m valid this cycle
in_ready  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
m  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  A+B or A-B, modulo 2^WIDTH
cout  output  1  raw carry out of MSB; for subtract 1 = no borrow
ovf  output  1  signed overflow
zero  output  1  result == 0
neg  output  1  result[WIDTH-1]

Behaviour:
- Reset (rst_n low, async): every stage valid bit, every data/carry/skew register, out_valid, result, cout, ovf, zero, neg go to 0. in_ready is combinational and equals 1 while out_valid is 0.
- Global advance enable: adv = out_ready | ~out_valid. in_ready = adv.
- Transfer at input: in_valid & in_ready. Transfer at output: out_valid & out_ready.
- When adv is 1, every stage shifts forward one place, including bubbles (valid = 0). When adv is 0, all registers hold.
- Stage k (0..STAGES-1) adds chunk k of A and (B ^ {WIDTH{m}}) plus the carry-in from stage k-1. Stage 0 carry-in is m.
- Upper operand chunks travel through skew registers so each chunk reaches its stage together with the matching carry. Lower result chunks travel through deskew registers so the full result emerges aligned.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no stall. With STAGES=1 the result is registered once. Throughput is 1 op/cycle.
- Flags are computed in the final stage:
  - cout = carry out of MSB.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|result.
  - neg = result MSB.
  - All flags register together with result.
- Outputs stay stable while out_valid & ~out_ready (hold invariant).
- Ordering: results leave in acceptance order. No drop or duplication under any out_ready pattern.
- Wrap-around: the result is modulo 2^WIDTH. No saturation.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full rate.
- Reset asserted mid-operation discards all in-flight operations. After release, the first output appears only from operands accepted after release.
- Mode is per-operation. Alternating m every cycle must give correct results, because m travels with its operands through the pipeline.

Decomposition:
- Shared package (ak_addsub_pkg): localparam CW derivation, and a width/parameter legality check (WIDTH % STAGES == 0, elaboration error otherwise).
- One natural sub-module: ak_addsub_chunk, a CW-bit ripple add with carry-in, carry-out and carry-into-MSB (for ovf). It is instantiated STAGES times in a generate loop and reuses the existing 1-bit full adder cell internally.
- Pipeline registers, skew/deskew and handshake logic stay in the top module.

Test Plan:
- WIDTH=16, STAGES=4: A=0x00FF, B=0x0001, m=0 -> after 4 cycles result=0x0100, cout=0, ovf=0, zero=0, neg=0.
- A=0x7FFF, B=0x0001, m=0 -> result=0x8000, ovf=1, neg=1, cout=0. Also A=0xFFFF, B=0x0001 -> result=0x0000, cout=1, zero=1, ovf=0.
- Subtract: A=0x0005, B=0x0007, m=1 -> result=0xFFFE, cout=0 (borrow), ovf=0, neg=1. A=0x8000, B=0x0001, m=1 -> result=0x7FFF, cout=1, ovf=1.
- Back-to-back stream of 8 ops with alternating m, out_ready tied 1 -> 8 consecutive out_valid cycles starting at cycle 4, matching a reference model in order.
- Backpressure: stream 6 ops, out_ready low for cycles 5-7 -> in_ready low while stalled, result/flags held stable, all 6 results delivered in order with none lost.
- Reset: rst_n pulsed low for 1 cycle with 3 ops in flight -> outputs 0 immediately (async), out_valid stays 0 until 4 cycles after the first post-reset accept. Repeat the A=0x00FF+0x0001 case with STAGES=1 and STAGES=16 -> latency 1 and 16 cycles respectively.
